// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared fetch front-end constants
package fetch_sequencer_pkg;

    localparam int          FS_WORD_SIZE = 32;
    localparam logic [31:0] FS_RESET_PC  = 32'h0000_0000;
    localparam int          FS_DEPTH     = 2;

    typedef logic [1:0] fetch_count_t;

endpackage

// File: rtl/fetch_sequencer_fifo.sv
// rtl/fetch_sequencer_fifo.sv - 2-entry circular prefetch buffer with flush
module fetch_sequencer_fifo
    import fetch_sequencer_pkg::*;
#(
    parameter int WIDTH = 2 * FS_WORD_SIZE
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [WIDTH-1:0]   i_wdata,
    output logic [WIDTH-1:0]   o_rdata,
    output fetch_count_t       o_count
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    fetch_count_t     r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            // Storage is left alone; only the bookkeeping is discarded.
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and fetch/redirect/halt control feeding decode
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                   WORD_SIZE = FS_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(FS_RESET_PC)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic [WORD_SIZE-1:0] o_imem_addr,
    input  logic [WORD_SIZE-1:0] i_imem_data,
    input  logic                 i_redirect_valid,
    input  logic [WORD_SIZE-1:0] i_redirect_pc,
    input  logic                 i_halt,
    output logic                 o_inst_valid,
    output logic [WORD_SIZE-1:0] o_inst_data,
    output logic [WORD_SIZE-1:0] o_inst_pc,
    input  logic                 i_inst_ready,
    output logic [1:0]           o_buf_count
);

    logic [WORD_SIZE-1:0]   r_fetch_pc;
    logic                   w_pop;
    logic                   w_push;
    fetch_count_t           w_count;
    logic [2*WORD_SIZE-1:0] w_rdata;

    assign w_pop  = o_inst_valid & i_inst_ready;
    // A full buffer can still take a word when decode frees the head this cycle.
    assign w_push = ~i_halt & ~i_redirect_valid &
                    ((w_count < fetch_count_t'(FS_DEPTH)) | w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (i_redirect_valid) begin
            r_fetch_pc <= i_redirect_pc;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 1'b1;
        end
    end

    fetch_sequencer_fifo #(
        .WIDTH (2 * WORD_SIZE)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .i_wdata ({r_fetch_pc, i_imem_data}),
        .o_rdata (w_rdata),
        .o_count (w_count)
    );

    assign o_imem_addr  = r_fetch_pc;
    assign o_inst_valid = (w_count != 2'd0);
    assign o_inst_pc    = w_rdata[2*WORD_SIZE-1:WORD_SIZE];
    assign o_inst_data  = w_rdata[WORD_SIZE-1:0];
    assign o_buf_count  = w_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic [31:0] imem_addr, imem_data, inst_data, inst_pc;
    logic        inst_valid;
    logic [1:0]  buf_count;

    logic [31:0] d2_imem_addr, d2_imem_data, d2_inst_data, d2_inst_pc;
    logic        d2_inst_valid;
    logic [1:0]  d2_buf_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mq [$];
    logic [31:0] mpc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data    = imem_addr + 32'h1000;
    assign d2_imem_data = d2_imem_addr + 32'h1000;

    fetch_sequencer dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_addr      (imem_addr),
        .i_imem_data      (imem_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_halt           (halt),
        .o_inst_valid     (inst_valid),
        .o_inst_data      (inst_data),
        .o_inst_pc        (inst_pc),
        .i_inst_ready     (inst_ready),
        .o_buf_count      (buf_count)
    );

    fetch_sequencer #(
        .WORD_SIZE (32),
        .RESET_PC  (32'hFFFF_FFFE)
    ) dut_wrap (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_addr      (d2_imem_addr),
        .i_imem_data      (d2_imem_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_halt           (halt),
        .o_inst_valid     (d2_inst_valid),
        .o_inst_data      (d2_inst_data),
        .o_inst_pc        (d2_inst_pc),
        .i_inst_ready     (inst_ready),
        .o_buf_count      (d2_buf_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs, compare outputs against the queue model, then
    // advance the model by the fetch rules once the clock edge has happened.
    task automatic step(input logic h, input logic rv, input logic [31:0] rp, input logic rdy);
        logic pop;
        logic push;
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rp;
        inst_ready     = rdy;
        #1;
        check_val("valid", {31'b0, inst_valid}, {31'b0, (mq.size() != 0)});
        check_val("count", {30'b0, buf_count}, mq.size());
        check_val("imem_addr", imem_addr, mpc);
        if (mq.size() != 0) begin
            check_val("inst_pc", inst_pc, mq[0]);
            check_val("inst_data", inst_data, mq[0] + 32'h1000);
        end
        pop  = (mq.size() != 0) && rdy;
        push = !h && !rv && ((mq.size() < 2) || pop);
        @(posedge clk);
        #1;
        if (rv) begin
            mq.delete();
            mpc = rp;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(mpc);
                mpc = mpc + 32'd1;
            end
        end
    endtask

    task automatic do_reset(input logic check_async);
        #3;
        rst            = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        if (check_async) begin
            check_val("async_valid", {31'b0, inst_valid}, 32'd0);
            check_val("async_count", {30'b0, buf_count}, 32'd0);
            check_val("async_addr", imem_addr, 32'd0);
            check_val("async_addr_wrap", d2_imem_addr, 32'hFFFF_FFFE);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mpc = 32'd0;
    endtask

    initial begin
        rst            = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inst_ready     = 1'b0;
        mpc            = 32'd0;
        #1;
        check_val("rst_valid", {31'b0, inst_valid}, 32'd0);
        check_val("rst_count", {30'b0, buf_count}, 32'd0);
        check_val("rst_data", inst_data, 32'd0);
        check_val("rst_pc", inst_pc, 32'd0);
        check_val("rst_addr", imem_addr, 32'd0);
        check_val("rst_addr_wrap", d2_imem_addr, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming from reset, plus the wrapping instance alongside.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            check_val("s1_pc", inst_pc, k);
            check_val("s1_data", inst_data, 32'h1000 + k);
            check_val("s5_pc", d2_inst_pc, 32'hFFFF_FFFE + k);
            check_val("s5_data", d2_inst_data, 32'hFFFF_FFFE + k + 32'h1000);
        end

        // Back-pressure then release.
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
        check_val("s2_count", {30'b0, buf_count}, 32'd2);
        check_val("s2_addr", imem_addr, 32'd2);
        check_val("s2_head", inst_pc, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_val("s2_pc", inst_pc, k);
            step(1'b0, 1'b0, 32'd0, 1'b1);
        end

        // Redirect with pcs 5,6 buffered.
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check_val("s3_count", {30'b0, buf_count}, 32'd2);
        check_val("s3_head", inst_pc, 32'd5);
        step(1'b0, 1'b1, 32'h40, 1'b0);
        check_val("s3_flush_valid", {31'b0, inst_valid}, 32'd0);
        check_val("s3_flush_addr", imem_addr, 32'h40);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_val("s3_tgt_pc", inst_pc, 32'h40);
        check_val("s3_tgt_data", inst_data, 32'h1040);

        // Halt drains the buffer and freezes the PC.
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check_val("s4_count", {30'b0, buf_count}, 32'd2);
        check_val("s4_head", inst_pc, 32'd2);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'd0, 1'b1);
        check_val("s4_valid", {31'b0, inst_valid}, 32'd0);
        check_val("s4_addr", imem_addr, 32'd4);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_val("s4_resume_pc", inst_pc, 32'd4);

        // Asynchronous reset with a full buffer.
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
        check_val("s6_full", {30'b0, buf_count}, 32'd2);
        do_reset(1'b1);

        for (int n = 0; n < 600; n++) begin
            int r;
            logic [31:0] rp;
            r  = $urandom_range(0, 99);
            rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD + $urandom_range(0, 2) : $urandom;
            if (r < 2) begin
                do_reset(1'b1);
            end else begin
                step(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), rp,
                     ($urandom_range(0, 2) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the CPU front end. Owns the program counter, drives the address of the combinational instruction memory (`inst_memory`), and captures each fetched word into a 2-entry prefetch buffer. The buffer feeds decode through a valid/ready handshake. The block also handles branch redirects (flush and re-steer) and halt (stop fetching, drain buffer).

Parameters:
- WORD_SIZE, 32, width of instruction word and of PC (word-addressed).
- RESET_PC, 0, PC value loaded on reset.
- DEPTH, 2, prefetch buffer entries; fixed at 2 for this revision.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  WORD_SIZE  address to `inst_memory`; equals the current fetch PC.
- imem_data  input  WORD_SIZE  instruction word from `inst_memory`; combinational from imem_addr, same cycle.
- redirect_valid  input  1  branch/jump taken; re-steer fetch.
- redirect_pc  input  WORD_SIZE  target PC, sampled when redirect_valid=1.
- halt  input  1  level; suppresses new fetches while high.
- inst_valid  output  1  buffer head holds a valid instruction.
- inst_data  output  WORD_SIZE  instruction at buffer head.
- inst_pc  output  WORD_SIZE  PC of inst_data.
- inst_ready  input  1  decode accepts head this cycle.
- buf_count  output  2  occupancy, 0..2.

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, so imem_addr=RESET_PC. buf_count=0, inst_valid=0, inst_data=0, inst_pc=0. All buffer storage cleared to 0.
- State: fetch_pc register; 2-entry circular FIFO of {pc, data} with rd_ptr, wr_ptr (1 bit each) and count.
- pop = inst_valid & inst_ready.
- push = !halt & !redirect_valid & (count<2 | pop).
  - A full buffer accepts a push in the same cycle as a pop.
- On push, at the clock edge:
  - write {fetch_pc, imem_data} at wr_ptr;
  - fetch_pc <= fetch_pc+1, wrapping modulo 2^WORD_SIZE (all-ones → 0, no flag).
- Latency: a word fetched in cycle N appears on inst_data in cycle N+1. After reset release, first inst_valid=1 at the first edge, with inst_pc=RESET_PC.
- Throughput: one instruction per cycle when inst_ready is held high.
- Outputs:
  - inst_valid = (count!=0).
  - inst_data and inst_pc come from entry rd_ptr.
  - When empty, inst_data and inst_pc hold the last head value; they are don't-care to decode but must not be X after reset.
- Redirect (highest priority after reset):
  - at the edge: count<=0, rd_ptr=wr_ptr=0, fetch_pc<=redirect_pc, no push;
  - a pop in the same cycle is accepted by decode, then flushed with everything else;
  - next cycle: imem_addr=redirect_pc, inst_valid=0;
  - the following edge pushes the target.
- Redirect while halt=1: PC still updates, buffer still flushes, no fetch until halt drops.
- Halt: no pushes, fetch_pc frozen. Pops continue, so the buffer drains to 0. On halt release, fetching resumes at the frozen fetch_pc with no skipped or duplicated PC.
- Back-pressure: with inst_ready=0 the buffer fills to 2 and fetch_pc stalls at head_pc+2. inst_data/inst_pc stay stable while inst_valid=1 and inst_ready=0.
- Simultaneous push+pop at count=1 or 2: count unchanged, both pointers advance.
- Reset asserted mid-stream: everything returns to reset values asynchronously; buffered instructions are lost.

Decomposition:
- Shared `parameters.v` gains RESET_PC and FETCH_DEPTH next to WORD_SIZE. No new typedefs; the block includes that file like the rest of the CPU.
- One sub-module is natural: `fetch_fifo` (2-entry, 2×WORD_SIZE-wide circular buffer with count, push/pop/flush inputs).
- The top level holds the PC and the push/priority logic.

Test Plan:
All scenarios use a bench memory model with imem_data = addr + 0x1000.
1. Reset release, inst_ready=1 → inst_pc sequence 0,1,2,3 on consecutive cycles with inst_data 0x1000..0x1003; inst_valid=1 from cycle 1.
2. inst_ready=0 for 5 cycles after reset → buf_count reaches 2, imem_addr holds 2, inst_pc holds 0. Raising ready then yields pcs 0,1,2,3 with no gap or duplicate.
3. redirect_valid=1 with redirect_pc=0x40 while buffer holds pcs 5,6 → next cycle inst_valid=0 and imem_addr=0x40; following cycle inst_pc=0x40, inst_data=0x1040.
4. halt=1 at count=2 with ready=1 → pcs 2,3 drain, then inst_valid=0 and imem_addr frozen. Dropping halt → next inst_pc=4.
5. RESET_PC=32'hFFFF_FFFE, ready=1 → inst_pc sequence FFFF_FFFE, FFFF_FFFF, 0, 1.
6. Assert rst asynchronously mid-cycle with count=2 → inst_valid and buf_count go to 0 immediately, without waiting for a clk edge; imem_addr=RESET_PC.
